eth_tx_frame_arbiter: RTL and testbench
=======================================

Name: eth_tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one GMII transmit path (axis_gmii_tx, 8-bit AXI-stream in) between PORTS AXI-stream sources, e.g. the host DMA TX queue and a local PAUSE/ARP responder.
- Grants one source per frame and holds the grant until that frame's tlast handshake, so frames are never interleaved.
- Sits directly in front of the transmitter's s_axis input in the ethernet_controller TX path.

Parameters:
- PORTS, 2, number of requesting streams; legal range 2..4.
- DATA_WIDTH, 8, tdata width; must be 8.
- USER_WIDTH, 1, tuser width; passed through unchanged.
- CNT_WIDTH, 16, width of each per-port frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_axis_tdata  in  PORTS*DATA_WIDTH  per-port data; port i occupies bits [i*8+:8].
- s_axis_tvalid  in  PORTS  per-port valid.
- s_axis_tready  out  PORTS  per-port ready.
- s_axis_tlast  in  PORTS  per-port end of frame.
- s_axis_tuser  in  PORTS*USER_WIDTH  per-port user; bit 0 is the frame-error flag.
- m_axis_tdata  out  DATA_WIDTH  to transmitter.
- m_axis_tvalid  out  1  to transmitter.
- m_axis_tready  in  1  from transmitter.
- m_axis_tlast  out  1  to transmitter.
- m_axis_tuser  out  USER_WIDTH  to transmitter.
- hold  in  1  when high, no new grant is issued; a frame already in progress completes.
- grant_valid  out  1  high while a frame is granted.
- grant_idx  out  2  index of the granted port; holds its last value when idle.
- frame_count  out  PORTS*CNT_WIDTH  per-port count of completed frames.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high. All registers clear immediately on rst assertion.
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0, all frame_count=0. Because m_axis_tvalid=0 and s_axis_tready=0 in IDLE, both are 0 during reset.
- State IDLE:
  - m_axis_tvalid=0; all s_axis_tready=0.
  - If hold=0 and any s_axis_tvalid is set: select the first set bit found scanning from rr_ptr upward with modulo-PORTS wrap.
  - Register the selection into grant_idx, set grant_valid=1, go to BUSY.
  - Grant decision takes 1 cycle. Data first appears on m_axis the cycle after the request is seen.
- State BUSY (combinational pass-through, no added pipeline latency):
  - m_axis_{tdata,tvalid,tlast,tuser} = the granted port's fields.
  - s_axis_tready[grant_idx] = m_axis_tready; every other port's tready=0.
  - hold is ignored in BUSY.
  - A tvalid drop from the granted source is passed through unchanged; the transmitter flags the underflow.
- End of frame: on m_axis_tvalid & m_axis_tready & m_axis_tlast in BUSY:
  - frame_count[grant_idx] increments by 1, wrapping at 2^CNT_WIDTH.
  - rr_ptr = (grant_idx+1) mod PORTS.
  - grant_valid=0 next cycle; state returns to IDLE.
  - There is at least one IDLE cycle between frames; the transmitter's IFG absorbs it.
- Error frames: frames with tuser[0]=1 are counted the same as clean frames.
- Fairness: a port that has just been served has the lowest priority at the next arbitration. With all PORTS ports requesting continuously, grants rotate 0,1,..,PORTS-1,0.
- Simultaneous events:
  - hold rising in the same cycle as an IDLE request: no grant is issued.
  - A new request arriving in the tlast-handshake cycle is considered in the following IDLE cycle.
- Reset mid-frame: outputs drop to 0 asynchronously and the partial frame is abandoned. The source is responsible for flushing.

Test Plan:
- Basic grant: reset; port1 sends a 3-byte frame (0xA1,0xA2,0xA3 with tlast), m_tready=1. Expect grant_idx=1 one cycle after tvalid; m_tdata sequence A1,A2,A3; frame_count[1]=1; rr_ptr=0 after the frame; grant_valid=0 the cycle after tlast.
- Round-robin: ports 0 and 1 each request 4 back-to-back 2-byte frames. Expect grant order 0,1,0,1,0,1,0,1; both counters reach 4; exactly one idle cycle between frames.
- No interleave under backpressure: port0 mid-frame with m_tready toggling 1,0,1,0 while port1 asserts tvalid. Expect s_tready[1]=0 throughout, port0 bytes in order, and port1 granted only after port0's tlast.
- Hold: hold=1 with both ports valid. Expect no grant for 10 cycles. Deassert hold and expect a grant next cycle. Then assert hold during a BUSY frame and expect that frame to complete.
- Reset mid-frame: assert rst asynchronously (between clock edges) during byte 2 of a frame. Expect m_tvalid=0, s_tready=0, grant_valid=0 immediately and all counters 0. After release, a fresh arbitration starts at port 0.
- Counter wrap: force frame_count[0]=0xFFFF via 65535 single-byte frames or a backdoor load, then send one more frame. Expect 0x0000 with other counters unchanged.

Source files
------------

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_frame_arbiter
// Brief    : Frame-granular round-robin arbiter sharing one AXI-stream TX path.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_frame_arbiter #(
   parameter int PORTS      = 2,
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [PORTS-1:0]            s_axis_tvalid,
   output logic [PORTS-1:0]            s_axis_tready,
   input  logic [PORTS-1:0]            s_axis_tlast,
   input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic [USER_WIDTH-1:0]       m_axis_tuser,
   input  logic                        hold,
   output logic                        grant_valid,
   output logic [1:0]                  grant_idx,
   output logic [PORTS*CNT_WIDTH-1:0]  frame_count
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_rr_ptr;
   logic [1:0] r_grant_idx;
   logic [1:0] w_pick;
   logic [1:0] w_next_ptr;
   logic       w_pick_found;
   logic       w_grant;
   logic       w_eof;

   // Two passes give the rotated priority: ports at or above rr_ptr first, then the wrap.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick       = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (!w_pick_found && s_axis_tvalid[p] && (2'(p) >= r_rr_ptr)) begin
            w_pick_found = 1'b1;
            w_pick       = 2'(p);
         end
      end
      for (int p = 0; p < PORTS; p++) begin
         if (!w_pick_found && s_axis_tvalid[p] && (2'(p) < r_rr_ptr)) begin
            w_pick_found = 1'b1;
            w_pick       = 2'(p);
         end
      end
   end

   assign w_grant    = (r_state == ST_IDLE) && !hold && w_pick_found;
   assign w_next_ptr = (r_grant_idx == 2'(PORTS - 1)) ? 2'd0 : r_grant_idx + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = '0;
      s_axis_tready = '0;
      w_eof         = 1'b0;
      if (r_state == ST_BUSY) begin
         for (int p = 0; p < PORTS; p++) begin
            if (r_grant_idx == 2'(p)) begin
               m_axis_tdata     = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
               m_axis_tvalid    = s_axis_tvalid[p];
               m_axis_tlast     = s_axis_tlast[p];
               m_axis_tuser     = s_axis_tuser[p*USER_WIDTH +: USER_WIDTH];
               s_axis_tready[p] = m_axis_tready;
               w_eof            = s_axis_tvalid[p] && s_axis_tlast[p] && m_axis_tready;
            end
         end
         if (w_eof) begin
            w_state_next = ST_IDLE;
         end
      end else if (w_grant) begin
         w_state_next = ST_BUSY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_idx <= '0;
         r_rr_ptr    <= '0;
      end else begin
         if (w_grant) begin
            r_grant_idx <= w_pick;
         end
         if (w_eof) begin
            r_rr_ptr <= w_next_ptr;
         end
      end
   end

   assign grant_valid = (r_state == ST_BUSY);
   assign grant_idx   = r_grant_idx;

   for (genvar gp = 0; gp < PORTS; gp++) begin : g_cnt
      logic [CNT_WIDTH-1:0] r_count;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_count <= '0;
         end else if (w_eof && (r_grant_idx == 2'(gp))) begin
            r_count <= r_count + CNT_WIDTH'(1);
         end
      end
      assign frame_count[gp*CNT_WIDTH +: CNT_WIDTH] = r_count;
   end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_frame_arbiter
// Brief    : Directed self-checking bench for eth_tx_frame_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_frame_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_tdata;
   logic [1:0]  s_tvalid, s_tready, s_tlast, s_tuser;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic [0:0]  m_tuser;
   logic        hold;
   logic        grant_valid;
   logic [1:0]  grant_idx;
   logic [31:0] frame_count;
   logic [15:0] fc0, fc1;

   logic [1:0]  w_s_tready;
   logic [7:0]  w_m_tdata;
   logic        w_m_tvalid, w_m_tlast, w_grant_valid;
   logic [0:0]  w_m_tuser;
   logic [1:0]  w_grant_idx;
   logic [7:0]  w_frame_count;

   logic [7:0]  d0, d1;
   logic        v0, v1, l0, l1, u0, u1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  byte_q[$];
   logic [1:0]  gnt_q[$];
   int          gap_q[$];
   int          idle_run = 0;
   logic        gv_prev  = 1'b0;
   logic        done0;
   logic        leak;

   assign s_tdata  = {d1, d0};
   assign s_tvalid = {v1, v0};
   assign s_tlast  = {l1, l0};
   assign s_tuser  = {u1, u0};
   assign fc0      = frame_count[15:0];
   assign fc1      = frame_count[31:16];

   always #5 clk = ~clk;

   eth_tx_frame_arbiter #(.PORTS(2), .DATA_WIDTH(8), .USER_WIDTH(1), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .hold(hold), .grant_valid(grant_valid), .grant_idx(grant_idx),
      .frame_count(frame_count)
   );

   // Narrow-counter copy on the same stimulus, so counter wrap is reachable quickly.
   eth_tx_frame_arbiter #(.PORTS(2), .DATA_WIDTH(8), .USER_WIDTH(1), .CNT_WIDTH(4)) dut_w (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(w_s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(w_m_tdata), .m_axis_tvalid(w_m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(w_m_tlast), .m_axis_tuser(w_m_tuser),
      .hold(hold), .grant_valid(w_grant_valid), .grant_idx(w_grant_idx),
      .frame_count(w_frame_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drv(input int port, input logic v, input logic [7:0] d, input logic l, input logic u);
      if (port == 0) begin
         v0 = v; d0 = d; l0 = l; u0 = u;
      end else begin
         v1 = v; d1 = d; l1 = l; u1 = u;
      end
   endtask

   // Called just after a rising edge; returns just after the edge that took the last byte.
   task automatic src_frame(input int port, input int len, input logic [7:0] base, input logic err);
      int guard;
      for (int k = 0; k < len; k++) begin
         drv(port, 1'b1, base + 8'(k), (k == len - 1), err);
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (!s_tready[port] && guard < 200);
         if (guard >= 200) check("src_timeout", 32'(guard), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic src_frames(input int port, input int n, input logic [7:0] base, input logic err);
      for (int f = 0; f < n; f++) src_frame(port, 2, base + 8'(2 * f), err);
      drv(port, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         idle_run = 0;
         gv_prev  = 1'b0;
      end else begin
         if (m_tvalid && m_tready) begin
            byte_q.push_back(m_tdata);
            if (m_tlast) gnt_q.push_back(grant_idx);
         end
         if (grant_valid && !gv_prev) gap_q.push_back(idle_run);
         idle_run = grant_valid ? 0 : idle_run + 1;
         gv_prev  = grant_valid;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_b [6];
      int guard;
      exp_b = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h51};
      drv(0, 1'b0, 8'h00, 1'b0, 1'b0);
      drv(1, 1'b0, 8'h00, 1'b0, 1'b0);
      m_tready = 1'b1;
      hold     = 1'b0;
      done0    = 1'b0;
      leak     = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_gv", 32'(grant_valid), 32'd0);
      check("rst_gidx", 32'(grant_idx), 32'd0);
      check("rst_mvalid", 32'(m_tvalid), 32'd0);
      check("rst_sready", 32'(s_tready), 32'd0);
      check("rst_fc", frame_count, 32'd0);
      #2 rst = 1'b0;

      // Basic grant: port1 sends A1,A2,A3
      @(posedge clk); #1;
      drv(1, 1'b1, 8'hA1, 1'b0, 1'b0);
      @(negedge clk);
      check("basic_decide_gv", 32'(grant_valid), 32'd0);
      check("basic_decide_mvalid", 32'(m_tvalid), 32'd0);
      @(negedge clk);
      check("basic_gv", 32'(grant_valid), 32'd1);
      check("basic_gidx", 32'(grant_idx), 32'd1);
      check("basic_b0", 32'(m_tdata), 32'hA1);
      check("basic_sready", 32'(s_tready), 32'b10);
      check("basic_muser", 32'(m_tuser), 32'd0);
      @(posedge clk); #1;
      drv(1, 1'b1, 8'hA2, 1'b0, 1'b0);
      @(negedge clk);
      check("basic_b1", 32'(m_tdata), 32'hA2);
      @(posedge clk); #1;
      drv(1, 1'b1, 8'hA3, 1'b1, 1'b0);
      @(negedge clk);
      check("basic_b2", 32'(m_tdata), 32'hA3);
      check("basic_tlast", 32'(m_tlast), 32'd1);
      @(posedge clk); #1;
      drv(1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      check("basic_gv_after", 32'(grant_valid), 32'd0);
      check("basic_fc1", 32'(fc1), 32'd1);
      check("basic_fc0", 32'(fc0), 32'd0);

      // Round-robin: 4 back-to-back 2-byte frames per port
      @(posedge clk); #1;
      byte_q.delete(); gnt_q.delete(); gap_q.delete();
      fork
         src_frames(0, 4, 8'h00, 1'b0);
         src_frames(1, 4, 8'h10, 1'b0);
      join
      @(negedge clk);
      check("rr_nframes", 32'(gnt_q.size()), 32'd8);
      for (int k = 0; k < gnt_q.size() && k < 8; k++)
         check("rr_order", 32'(gnt_q[k]), 32'(k % 2));
      check("rr_ngaps", 32'(gap_q.size()), 32'd8);
      for (int k = 1; k < gap_q.size() && k < 8; k++)
         check("rr_idle_gap", 32'(gap_q[k]), 32'd1);
      check("rr_fc0", 32'(fc0), 32'd4);
      check("rr_fc1", 32'(fc1), 32'd5);

      // No interleave under backpressure
      @(posedge clk); #1;
      byte_q.delete(); gnt_q.delete();
      fork
         begin
            src_frame(0, 4, 8'h40, 1'b0);
            drv(0, 1'b0, 8'h00, 1'b0, 1'b0);
            done0 = 1'b1;
         end
         begin
            @(posedge clk); #1;
            src_frame(1, 2, 8'h50, 1'b0);
            drv(1, 1'b0, 8'h00, 1'b0, 1'b0);
         end
         begin
            for (int k = 0; k < 8; k++) begin
               m_tready = ((k % 2) == 0);
               @(posedge clk); #1;
            end
            m_tready = 1'b1;
         end
         begin
            for (int g = 0; g < 100 && !done0; g++) begin
               @(negedge clk);
               if (s_tready[1]) leak = 1'b1;
            end
         end
      join
      @(negedge clk);
      check("bp_port1_ready_leak", 32'(leak), 32'd0);
      check("bp_nbytes", 32'(byte_q.size()), 32'd6);
      for (int k = 0; k < byte_q.size() && k < 6; k++)
         check("bp_byte", 32'(byte_q[k]), 32'(exp_b[k]));
      check("bp_nframes", 32'(gnt_q.size()), 32'd2);
      if (gnt_q.size() == 2) begin
         check("bp_first", 32'(gnt_q[0]), 32'd0);
         check("bp_second", 32'(gnt_q[1]), 32'd1);
      end

      // Hold
      @(posedge clk); #1;
      hold = 1'b1;
      fork
         src_frames(0, 1, 8'h60, 1'b0);
         src_frames(1, 1, 8'h70, 1'b1);
      join_none
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("hold_no_grant", 32'(grant_valid), 32'd0);
      end
      @(posedge clk); #1;
      hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("hold_release_gv", 32'(grant_valid), 32'd1);
      check("hold_release_gidx", 32'(grant_idx), 32'd0);
      @(posedge clk); #1;
      hold = 1'b1;
      for (guard = 0; guard < 20 && fc0 != 16'd6; guard++) @(negedge clk);
      check("hold_busy_completes", 32'(fc0), 32'd6);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_after_frame", 32'(grant_valid), 32'd0);
      end
      check("hold_fc1_blocked", 32'(fc1), 32'd6);
      @(posedge clk); #1;
      hold = 1'b0;
      for (guard = 0; guard < 20 && fc1 != 16'd7; guard++) @(negedge clk);
      check("hold_err_frame_counted", 32'(fc1), 32'd7);
      check("hold_fc0_final", 32'(fc0), 32'd6);
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-frame: move rr_ptr to 1, then abandon a port1 frame
      src_frames(0, 1, 8'h88, 1'b0);
      drv(1, 1'b1, 8'h90, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("mid_gidx", 32'(grant_idx), 32'd1);
      @(posedge clk); #1;
      drv(1, 1'b1, 8'h91, 1'b0, 1'b1);
      @(negedge clk);
      check("mid_b1", 32'(m_tdata), 32'h91);
      check("mid_user", 32'(m_tuser), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_mvalid", 32'(m_tvalid), 32'd0);
      check("arst_sready", 32'(s_tready), 32'd0);
      check("arst_gv", 32'(grant_valid), 32'd0);
      check("arst_fc", frame_count, 32'd0);
      check("arst_fc_narrow", 32'(w_frame_count), 32'd0);
      drv(1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      fork
         src_frames(0, 1, 8'hC0, 1'b0);
         src_frames(1, 1, 8'hD0, 1'b0);
      join_none
      @(negedge clk);
      @(negedge clk);
      check("post_rst_gidx", 32'(grant_idx), 32'd0);
      for (guard = 0; guard < 20 && fc1 != 16'd1; guard++) @(negedge clk);
      check("post_rst_fc", frame_count, {16'd1, 16'd1});
      repeat (2) @(posedge clk);
      #1;

      // Counter wrap on the 4-bit copy
      src_frames(0, 14, 8'h00, 1'b0);
      @(negedge clk);
      check("wrap_pre", 32'(w_frame_count), {24'd0, 4'd1, 4'hF});
      @(posedge clk); #1;
      src_frames(0, 1, 8'hE0, 1'b0);
      @(negedge clk);
      check("wrap_fc0", 32'(w_frame_count[3:0]), 32'd0);
      check("wrap_fc1_unchanged", 32'(w_frame_count[7:4]), 32'd1);
      check("wrap_wide_fc0", 32'(fc0), 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
